hazard_scheduler: RTL and testbench

- Sequential hazard controller for the five-stage pipeline.
- Keeps shadow scoreboard entries for in-flight register writes in the E, M and W stages, plus a busy counter for the multiply/divide unit.
- Drives the ID-stage forwarding selects (regRD1Forward/regRD2Forward) and the stall/bubble controls for the F, D and E pipeline registers.
- Sits beside the controller and decodes nothing itself; the D-stage decode supplies Tuse/Tnew.

---
 rtl/hazard_scheduler.sv | 118 +++++++++++
 tb/tb_hazard_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: shadow scoreboard of in-flight GRF writes (E/M/W) plus a
// mult/div busy counter; produces ID-stage forward selects and the F/D/E
// stall/bubble controls for the five-stage pipeline.
module hazard_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] regA1,
    input  logic [4:0] regA2,
    input  logic [1:0] TuseRs,
    input  logic [1:0] TuseRt,
    input  logic [4:0] regA3,
    input  logic       regWrite,
    input  logic [1:0] TnewD,
    input  logic       mdStart,
    input  logic       mdIsDiv,
    input  logic       mdUse,
    output logic       stall,
    output logic       enPC,
    output logic       enD,
    output logic       clrE,
    output logic [1:0] regRD1Forward,
    output logic [1:0] regRD2Forward,
    output logic       mdBusy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic [1:0] tnew;
    } entry_t;

    entry_t           e_ent;
    entry_t           m_ent;
    entry_t           w_ent;
    logic [CNT_W-1:0] md_count;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;

    // Remaining cycles until the result exists, one stage later.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Entry writes register a but cannot deliver it by the time it is consumed.
    function automatic logic pending(input entry_t ent, input logic [4:0] a,
                                     input logic [1:0] tuse);
        return ent.valid && (ent.addr == a) && (ent.tnew > tuse);
    endfunction

    // W entries always have tnew==0 by construction, so their term never
    // fires; it is kept so a longer-latency producer would still be covered.
    function automatic logic operand_stall(input logic [4:0] a, input logic [1:0] tuse,
                                           input entry_t e, input entry_t m,
                                           input entry_t w);
        return (a != 5'd0) && (tuse != 2'd3) &&
               (pending(e, a, tuse) || pending(m, a, tuse) || pending(w, a, tuse));
    endfunction

    // Youngest ready producer wins; W is covered by GRF write-through.
    function automatic logic [1:0] fwd_sel(input logic [4:0] a, input entry_t e,
                                           input entry_t m);
        if (a == 5'd0)
            return 2'd0;
        if (e.valid && (e.addr == a) && (e.tnew == 2'd0))
            return 2'd1;
        if (m.valid && (m.addr == a) && (m.tnew == 2'd0))
            return 2'd2;
        return 2'd0;
    endfunction

    // Hazard detection and forward selection from the current scoreboard.
    always_comb begin
        stall_rs      = operand_stall(regA1, TuseRs, e_ent, m_ent, w_ent);
        stall_rt      = operand_stall(regA2, TuseRt, e_ent, m_ent, w_ent);
        stall_md      = mdUse && mdBusy;
        stall         = stall_rs || stall_rt || stall_md;
        enPC          = ~stall;
        enD           = ~stall;
        clrE          = stall;
        regRD1Forward = fwd_sel(regA1, e_ent, m_ent);
        regRD2Forward = fwd_sel(regA2, e_ent, m_ent);
    end

    assign mdBusy = (md_count != '0);

    // Scoreboard advance; a stall injects a bubble into E, $0 is never tracked.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_ent <= '0;
            m_ent <= '0;
            w_ent <= '0;
        end else begin
            w_ent <= {m_ent.valid, m_ent.addr, tnew_dec(m_ent.tnew)};
            m_ent <= {e_ent.valid, e_ent.addr, tnew_dec(e_ent.tnew)};
            e_ent <= {regWrite && !stall && (regA3 != 5'd0), regA3, tnew_dec(TnewD)};
        end
    end

    // Mult/div busy counter; a new issue reloads even while counting down.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_count <= '0;
        end else if (mdStart && !stall) begin
            md_count <= mdIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_count != '0) begin
            md_count <= md_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed pipeline scenarios plus random traffic,
// all compared against a timestamp-based model of in-flight producers.
module tb_hazard_scheduler;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] regA1, regA2, regA3;
    logic [1:0] TuseRs, TuseRt, TnewD;
    logic       regWrite, mdStart, mdIsDiv, mdUse;
    logic       stall, enPC, enD, clrE, mdBusy;
    logic [1:0] regRD1Forward, regRD2Forward;

    always #5 clk = ~clk;

    hazard_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset),
        .regA1(regA1), .regA2(regA2), .TuseRs(TuseRs), .TuseRt(TuseRt),
        .regA3(regA3), .regWrite(regWrite), .TnewD(TnewD),
        .mdStart(mdStart), .mdIsDiv(mdIsDiv), .mdUse(mdUse),
        .stall(stall), .enPC(enPC), .enD(enD), .clrE(clrE),
        .regRD1Forward(regRD1Forward), .regRD2Forward(regRD2Forward),
        .mdBusy(mdBusy)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    logic       last_stall, last_busy;
    logic [1:0] last_f1, last_f2;

    // Reference model: every accepted writer remembered with its issue cycle.
    typedef struct {
        int addr;
        int tnew_d;
        int issue;
    } prod_t;

    prod_t prods[$];
    int    ncyc     = 0;
    int    busy_end = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    function automatic int remain(prod_t p);
        int r;
        r = p.tnew_d - (ncyc - p.issue);
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit op_stall(int a, int tuse);
        if (a == 0 || tuse == 3) return 1'b0;
        foreach (prods[i]) begin
            int age;
            age = ncyc - prods[i].issue;
            if ((age == 1 || age == 2) && prods[i].addr == a && remain(prods[i]) > tuse)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int op_fwd(int a);
        if (a == 0) return 0;
        for (int age = 1; age <= 2; age++)
            foreach (prods[i])
                if (ncyc - prods[i].issue == age && prods[i].addr == a && remain(prods[i]) == 0)
                    return age;
        return 0;
    endfunction

    task automatic set_in(input int a1, input int a2, input int trs, input int trt,
                          input int a3, input int wr, input int tn,
                          input int ms, input int md, input int mu);
        regA1 = 5'(a1); regA2 = 5'(a2); TuseRs = 2'(trs); TuseRt = 2'(trt);
        regA3 = 5'(a3); regWrite = 1'(wr); TnewD = 2'(tn);
        mdStart = 1'(ms); mdIsDiv = 1'(md); mdUse = 1'(mu);
    endtask

    task automatic idle();
        set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: sample at mid-cycle, compare to model, advance model, edge.
    task automatic cycle();
        bit m_stall, busy;
        int f1, f2;
        #4;
        busy    = (ncyc < busy_end);
        m_stall = op_stall(int'(regA1), int'(TuseRs)) || op_stall(int'(regA2), int'(TuseRt))
                  || (mdUse && busy);
        f1 = op_fwd(int'(regA1));
        f2 = op_fwd(int'(regA2));
        last_stall = stall; last_busy = mdBusy; last_f1 = regRD1Forward; last_f2 = regRD2Forward;
        if (armed) begin
            check("stall", 32'(stall), 32'(m_stall));
            check("enPC", 32'(enPC), 32'(!m_stall));
            check("enD", 32'(enD), 32'(!m_stall));
            check("clrE", 32'(clrE), 32'(m_stall));
            check("mdBusy", 32'(mdBusy), 32'(busy));
            if (!m_stall) begin
                check("fwd1", 32'(regRD1Forward), 32'(f1));
                check("fwd2", 32'(regRD2Forward), 32'(f2));
            end
        end
        if (reset) begin
            prods.delete();
            busy_end = 0;
        end else if (!m_stall) begin
            if (regWrite && regA3 != 0)
                prods.push_back('{addr: int'(regA3), tnew_d: int'(TnewD), issue: ncyc});
            if (mdStart)
                busy_end = ncyc + (mdIsDiv ? DIV_N : MULT_N) + 1;
        end
        ncyc++;
        while (prods.size() > 0 && ncyc - prods[0].issue > 2)
            void'(prods.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic md_test(input bit is_div, input int n_exp, input string tag);
        int stalls, busies;
        stalls = 0;
        busies = 0;
        set_in(0, 0, 3, 3, 0, 0, 0, 1, int'(is_div), 1);
        cycle();
        set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < n_exp + 6; k++) begin
            cycle();
            if (last_busy) busies++;
            if (last_stall) stalls++;
            else break;
        end
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(n_exp));
        check({tag, "_busy_cycles"}, 32'(busies), 32'(n_exp));
        idle();
        cycle();
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 3, 3, 5, 1, 1, 1, 1, 0);
        @(posedge clk);
        #1;
        // Reset with writes and a divide driven: first sample sees pre-reset state.
        cycle();
        armed = 1'b1;
        cycle();
        check("rst_stall", 32'(last_stall), 32'd0);
        check("rst_busy", 32'(last_busy), 32'd0);
        reset = 1'b0;
        regA1 = 5'd5;
        cycle();
        check("post_rst_stall", 32'(last_stall), 32'd0);
        check("post_rst_fwd1", 32'(last_f1), 32'd0);
        check("post_rst_busy", 32'(last_busy), 32'd0);
        idle();
        repeat (12) cycle();

        // ALU result feeding a branch comparator.
        set_in(0, 0, 3, 3, 8, 1, 2, 0, 0, 0); cycle();
        set_in(8, 0, 0, 3, 0, 0, 0, 0, 0, 0); cycle();
        check("alu_br_stall1", 32'(last_stall), 32'd1);
        cycle();
        check("alu_br_stall2", 32'(last_stall), 32'd0);
        check("alu_br_fwd", 32'(last_f1), 32'd2);
        idle(); repeat (3) cycle();

        // Load followed by an ALU use of the loaded register.
        set_in(0, 0, 3, 3, 9, 1, 3, 0, 0, 0); cycle();
        set_in(0, 9, 3, 1, 0, 0, 0, 0, 0, 0); cycle();
        check("load_use_stall1", 32'(last_stall), 32'd1);
        cycle();
        check("load_use_stall2", 32'(last_stall), 32'd0);
        idle(); repeat (3) cycle();

        // jal then jr $31.
        set_in(0, 0, 3, 3, 31, 1, 0, 0, 0, 0); cycle();
        set_in(31, 0, 0, 3, 0, 0, 0, 0, 0, 0); cycle();
        check("jal_stall", 32'(last_stall), 32'd0);
        check("jal_fwd", 32'(last_f1), 32'd1);
        idle(); repeat (3) cycle();

        // $0 is never a hazard nor forwarded.
        set_in(0, 0, 3, 3, 0, 1, 1, 0, 0, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        check("zero_stall", 32'(last_stall), 32'd0);
        check("zero_fwd1", 32'(last_f1), 32'd0);
        check("zero_fwd2", 32'(last_f2), 32'd0);
        idle(); repeat (3) cycle();

        // Two writers of $10: the younger one (in E) is selected.
        set_in(0, 0, 3, 3, 10, 1, 1, 0, 0, 0); cycle();
        cycle();
        set_in(10, 10, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        check("prio_stall", 32'(last_stall), 32'd0);
        check("prio_fwd1", 32'(last_f1), 32'd1);
        check("prio_fwd2", 32'(last_f2), 32'd1);
        idle(); repeat (3) cycle();

        md_test(1'b1, DIV_N, "div");
        md_test(1'b0, MULT_N, "mult");

        // Reset in the middle of a divide while mflo is stalled.
        set_in(0, 0, 3, 3, 0, 0, 0, 1, 1, 1); cycle();
        set_in(0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
        repeat (3) cycle();
        check("mid_div_stall", 32'(last_stall), 32'd1);
        reset = 1'b1; cycle();
        reset = 1'b0; cycle();
        check("mid_rst_stall", 32'(last_stall), 32'd0);
        check("mid_rst_busy", 32'(last_busy), 32'd0);
        idle(); repeat (2) cycle();

        // Random traffic on a small register set to provoke frequent hits.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            set_in($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                   ($urandom_range(0, 3) == 0));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
